// File: rtl/rv32_pipe_pkg.sv
// Shared RV32 pipeline constants and the register-address type used by the
// scoreboard, forwarding and register-file blocks.
package rv32_pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int SB_CNT_W   = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/sb_counter.sv
// One per-register in-flight counter: net +inc -dec_wb -dec_kill per edge,
// clamped to [0, max]; a net result below zero raises underflow_o.
module sb_counter
    import rv32_pipe_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             inc_i,
    input  logic             dec_wb_i,
    input  logic             dec_kill_i,
    output logic [CNT_W-1:0] count_o,
    output logic             underflow_o
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    int               sum;

    always_comb begin
        sum         = int'(count_q) + int'(inc_i) - int'(dec_wb_i) - int'(dec_kill_i);
        underflow_o = 1'b0;
        count_d     = count_q;
        if (sum < 0) begin
            underflow_o = 1'b1;
            count_d     = '0;
        end else if (sum > CNT_MAX) begin
            count_d = CNT_W'(CNT_MAX);
        end else begin
            count_d = CNT_W'(sum);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/long_latency_scoreboard.sv
// Tracks in-flight long-latency register writes (loads, MUL/DIV/REM) and stalls
// ID on dependent source reads; a same-cycle long WB resolves its own hazard.
module long_latency_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      ISSUE_EN,
    input  logic                      ISSUE_WRITE_EN,
    input  logic                      ISSUE_LONG,
    input  rv32_pipe_pkg::reg_addr_t  ISSUE_RD,
    input  rv32_pipe_pkg::reg_addr_t  ID_ADDR1,
    input  rv32_pipe_pkg::reg_addr_t  ID_ADDR2,
    input  logic                      ID_USES1,
    input  logic                      ID_USES2,
    input  logic                      WB_WRITE_EN,
    input  rv32_pipe_pkg::reg_addr_t  WB_REGISTER,
    input  logic                      WB_LONG,
    input  logic                      KILL_EN,
    input  rv32_pipe_pkg::reg_addr_t  KILL_RD,
    output logic                      STALL,
    output logic                      ISSUE_ACCEPT,
    output logic                      PENDING1,
    output logic                      PENDING2,
    output logic                      BUSY,
    output logic                      SB_ERROR
);

    import rv32_pipe_pkg::*;

    logic [NUM_REGS-1:0] inc_oh;
    logic [NUM_REGS-1:0] wb_oh;
    logic [NUM_REGS-1:0] kill_oh;
    logic [NUM_REGS-1:0] underflow;
    logic [CNT_W-1:0]    cnt [NUM_REGS];

    logic err_q;
    logic err_d;
    logic issue_long_req;
    logic issue_fire;
    logic wb_long;
    logic sat_stall;
    logic pend1;
    logic pend2;
    logic any_busy;

    function automatic logic src_pending(input logic uses, input reg_addr_t addr,
                                         input logic [CNT_W-1:0] c, input logic wb_hit);
        // A matching long WB this cycle is forwarded, so it removes one outstanding write.
        if (wb_hit) begin
            return uses && (addr != '0) && (c != CNT_W'(1));
        end
        return uses && (addr != '0) && (c != '0);
    endfunction

    assign issue_long_req = ISSUE_EN && ISSUE_WRITE_EN && ISSUE_LONG && (ISSUE_RD != '0);
    assign wb_long        = WB_WRITE_EN && WB_LONG;

    always_comb begin
        inc_oh  = '0;
        wb_oh   = '0;
        kill_oh = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc_oh[r]  = issue_fire && (ISSUE_RD == REG_ADDR_W'(r));
            wb_oh[r]   = wb_long && (WB_REGISTER == REG_ADDR_W'(r));
            kill_oh[r] = KILL_EN && (KILL_RD == REG_ADDR_W'(r));
        end
    end

    assign cnt[0]       = '0;
    assign underflow[0] = 1'b0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk_i       (CLK),
            .reset_i     (RESET),
            .inc_i       (inc_oh[g]),
            .dec_wb_i    (wb_oh[g]),
            .dec_kill_i  (kill_oh[g]),
            .count_o     (cnt[g]),
            .underflow_o (underflow[g])
        );
    end

    always_comb begin
        pend1 = src_pending(ID_USES1, ID_ADDR1, cnt[ID_ADDR1], wb_long && (WB_REGISTER == ID_ADDR1));
        pend2 = src_pending(ID_USES2, ID_ADDR2, cnt[ID_ADDR2], wb_long && (WB_REGISTER == ID_ADDR2));
        // Saturation check ignores WB relief to keep this off the WB timing path.
        sat_stall = issue_long_req && (cnt[ISSUE_RD] == '1);
    end

    always_comb begin
        any_busy = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            any_busy = any_busy | (cnt[r] != '0);
        end
    end

    assign PENDING1     = !RESET && pend1;
    assign PENDING2     = !RESET && pend2;
    assign STALL        = !RESET && (pend1 || pend2 || sat_stall);
    assign ISSUE_ACCEPT = ISSUE_EN && !STALL;
    assign issue_fire   = ISSUE_ACCEPT && ISSUE_WRITE_EN && ISSUE_LONG;
    assign BUSY         = !RESET && any_busy;

    assign err_d = err_q | (|underflow);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign SB_ERROR = err_q;

endmodule

// File: tb/tb_long_latency_scoreboard.sv
// Directed and random stimulus for long_latency_scoreboard, checked every cycle
// against a counter-array reference model.
module tb_long_latency_scoreboard;

    localparam int MAXC = 3;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       ISSUE_EN, ISSUE_WRITE_EN, ISSUE_LONG;
    logic [4:0] ISSUE_RD, ID_ADDR1, ID_ADDR2;
    logic       ID_USES1, ID_USES2;
    logic       WB_WRITE_EN, WB_LONG;
    logic [4:0] WB_REGISTER;
    logic       KILL_EN;
    logic [4:0] KILL_RD;
    logic       STALL, ISSUE_ACCEPT, PENDING1, PENDING2, BUSY, SB_ERROR;

    int   cnt_m [32];
    bit   err_m;
    int   total = 0;
    int   bad   = 0;
    logic e_stall, e_acc, e_p1, e_p2, e_busy;

    long_latency_scoreboard dut (
        .CLK(CLK), .RESET(RESET),
        .ISSUE_EN(ISSUE_EN), .ISSUE_WRITE_EN(ISSUE_WRITE_EN), .ISSUE_LONG(ISSUE_LONG),
        .ISSUE_RD(ISSUE_RD), .ID_ADDR1(ID_ADDR1), .ID_ADDR2(ID_ADDR2),
        .ID_USES1(ID_USES1), .ID_USES2(ID_USES2),
        .WB_WRITE_EN(WB_WRITE_EN), .WB_REGISTER(WB_REGISTER), .WB_LONG(WB_LONG),
        .KILL_EN(KILL_EN), .KILL_RD(KILL_RD),
        .STALL(STALL), .ISSUE_ACCEPT(ISSUE_ACCEPT), .PENDING1(PENDING1),
        .PENDING2(PENDING2), .BUSY(BUSY), .SB_ERROR(SB_ERROR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic int eff(input logic [4:0] s);
        return cnt_m[s] - ((WB_WRITE_EN && WB_LONG && WB_REGISTER == s) ? 1 : 0);
    endfunction

    task automatic model_outputs();
        bit sat;
        e_p1   = !RESET && ID_USES1 && ID_ADDR1 != 0 && eff(ID_ADDR1) != 0;
        e_p2   = !RESET && ID_USES2 && ID_ADDR2 != 0 && eff(ID_ADDR2) != 0;
        sat    = ISSUE_EN && ISSUE_WRITE_EN && ISSUE_LONG && ISSUE_RD != 0 && cnt_m[ISSUE_RD] == MAXC;
        e_stall = !RESET && (e_p1 || e_p2 || sat);
        e_acc  = ISSUE_EN && !e_stall;
        e_busy = 1'b0;
        for (int r = 1; r < 32; r++) if (cnt_m[r] != 0) e_busy = 1'b1;
        if (RESET) e_busy = 1'b0;
    endtask

    task automatic model_edge();
        if (RESET) begin
            for (int r = 0; r < 32; r++) cnt_m[r] = 0;
            err_m = 1'b0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                int n;
                n = cnt_m[r];
                if (e_acc && ISSUE_WRITE_EN && ISSUE_LONG && ISSUE_RD == r) n++;
                if (WB_WRITE_EN && WB_LONG && WB_REGISTER == r) n--;
                if (KILL_EN && KILL_RD == r) n--;
                if (n < 0) begin
                    n = 0;
                    err_m = 1'b1;
                end
                if (n > MAXC) n = MAXC;
                cnt_m[r] = n;
            end
        end
    endtask

    task automatic step();
        #1;
        model_outputs();
        check("stall", STALL, e_stall);
        check("accept", ISSUE_ACCEPT, e_acc);
        check("pending1", PENDING1, e_p1);
        check("pending2", PENDING2, e_p2);
        check("busy", BUSY, e_busy);
        check("sb_error", SB_ERROR, err_m);
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic idle();
        RESET = 0; ISSUE_EN = 0; ISSUE_WRITE_EN = 0; ISSUE_LONG = 0; ISSUE_RD = 0;
        ID_ADDR1 = 0; ID_ADDR2 = 0; ID_USES1 = 0; ID_USES2 = 0;
        WB_WRITE_EN = 0; WB_REGISTER = 0; WB_LONG = 0; KILL_EN = 0; KILL_RD = 0;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        ISSUE_EN = 1; ISSUE_WRITE_EN = 1; ISSUE_LONG = 1; ISSUE_RD = rd;
    endtask

    task automatic wb_long(input logic [4:0] rd);
        WB_WRITE_EN = 1; WB_LONG = 1; WB_REGISTER = rd;
    endtask

    function automatic logic [4:0] pick_reg();
        if ($urandom_range(0, 9) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 4));
    endfunction

    initial begin
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        err_m = 1'b0;
        idle();
        RESET = 1;
        @(posedge CLK);
        #1;

        // reset behaviour with an issue request present
        idle(); RESET = 1; issue_long(5'd5); ID_USES1 = 1; ID_ADDR1 = 5'd5;
        #1; check("rst_accept", ISSUE_ACCEPT, 1'b1); check("rst_stall", STALL, 1'b0);
        step();

        // load-use on x5
        idle(); issue_long(5'd5); step();
        idle(); ID_USES1 = 1; ID_ADDR1 = 5'd5; ISSUE_EN = 1; ISSUE_WRITE_EN = 1; ISSUE_RD = 5'd6;
        #1; check("lu_stall_c1", STALL, 1'b1); step();
        #1; check("lu_stall_c2", STALL, 1'b1); step();
        wb_long(5'd5);
        #1; check("lu_wb_stall", STALL, 1'b0); check("lu_wb_accept", ISSUE_ACCEPT, 1'b1); step();
        idle(); #1; check("lu_busy_after", BUSY, 1'b0); step();

        // x0 never tracked
        idle(); issue_long(5'd0); ID_USES1 = 1; ID_USES2 = 1;
        #1; check("x0_stall", STALL, 1'b0); step(); step();
        idle(); #1; check("x0_busy", BUSY, 1'b0); step();

        // saturation on x7
        idle(); issue_long(5'd7); step(); step(); step();
        #1; check("sat_stall", STALL, 1'b1); step();
        wb_long(5'd7);
        #1; check("sat_stall_wb", STALL, 1'b1); step();
        idle(); issue_long(5'd7);
        #1; check("sat_accept", ISSUE_ACCEPT, 1'b1); step();
        #1; check("sat_again", STALL, 1'b1); step();
        idle(); wb_long(5'd7); step(); step(); step();
        idle(); #1; check("sat_drained", BUSY, 1'b0); step();

        // same-cycle issue and WB on x9
        idle(); issue_long(5'd9); step();
        wb_long(5'd9);
        #1; check("x9_accept", ISSUE_ACCEPT, 1'b1); step();
        idle(); ID_USES2 = 1; ID_ADDR2 = 5'd9;
        #1; check("x9_pending", PENDING2, 1'b1); check("x9_stall", STALL, 1'b1); step();
        wb_long(5'd9);
        #1; check("x9_resolved", STALL, 1'b0); step();

        // kill underflow on x12
        idle(); KILL_EN = 1; KILL_RD = 5'd12;
        #1; check("kill_err_before", SB_ERROR, 1'b0); step();
        idle();
        for (int i = 0; i < 3; i++) begin
            #1; check("kill_err_held", SB_ERROR, 1'b1); step();
        end

        // reset discards pending x3/x4 and the error flag
        idle(); issue_long(5'd3); step(); step();
        issue_long(5'd4); step();
        idle(); RESET = 1; ID_USES1 = 1; ID_ADDR1 = 5'd3; issue_long(5'd4);
        #1; check("rst_mid_stall", STALL, 1'b0); check("rst_mid_busy", BUSY, 1'b0); step();
        idle(); ID_USES1 = 1; ID_ADDR1 = 5'd3; ID_USES2 = 1; ID_ADDR2 = 5'd4;
        #1; check("post_rst_stall", STALL, 1'b0); check("post_rst_busy", BUSY, 1'b0);
        check("post_rst_err", SB_ERROR, 1'b0); step();

        // random traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            idle();
            RESET          = ($urandom_range(0, 149) == 0);
            ISSUE_EN       = $urandom_range(0, 1);
            ISSUE_WRITE_EN = ($urandom_range(0, 4) != 0);
            ISSUE_LONG     = $urandom_range(0, 1);
            ISSUE_RD       = pick_reg();
            ID_USES1       = $urandom_range(0, 1);
            ID_USES2       = $urandom_range(0, 1);
            ID_ADDR1       = pick_reg();
            ID_ADDR2       = pick_reg();
            WB_WRITE_EN    = ($urandom_range(0, 9) < 4);
            WB_REGISTER    = pick_reg();
            WB_LONG        = ($urandom_range(0, 9) < 6);
            if (cnt_m[WB_REGISTER] == 0 && $urandom_range(0, 7) != 0) WB_LONG = 0;
            KILL_RD        = pick_reg();
            KILL_EN        = ($urandom_range(0, 11) == 0);
            if (cnt_m[KILL_RD] == 0 && $urandom_range(0, 7) != 0) KILL_EN = 0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/long_latency_scoreboard.md
# long_latency_scoreboard

Producer-side hazard tracker for the RV32IM pipeline. It records in-flight register writes from long-latency instructions (loads, MUL/DIV/REM), whose results the EX/MEM bypass cannot supply. It stalls ID when a source operand depends on such a write. The writeback forwarding control consumes the same WB write bus that retires entries here, and this block allows the final pending write to retire in the same cycle it is forwarded.

## Interface
Parameters:
- NUM_REGS, 32, architectural registers tracked; x0 never tracked
- CNT_W, 2, per-register in-flight counter width; max 2^CNT_W-1 writes outstanding per register

Ports:
- CLK  in  1  single clock, rising edge
- RESET  in  1  synchronous, active-high
- ISSUE_EN  in  1  instruction in ID requests advance to EX this cycle
- ISSUE_WRITE_EN  in  1  issuing instruction writes rd
- ISSUE_LONG  in  1  issuing instruction is load or M-extension op
- ISSUE_RD  in  5  issuing destination
- ID_ADDR1, ID_ADDR2  in  5 each  source registers of instruction in ID
- ID_USES1, ID_USES2  in  1 each  source actually read
- WB_WRITE_EN  in  1  register-file write this cycle
- WB_REGISTER  in  5  register-file write address
- WB_LONG  in  1  WB write comes from a long-latency instruction
- KILL_EN  in  1  squashed long-latency instruction leaves pipeline without writing
- KILL_RD  in  5  its destination
- STALL  out  1  hold ID and PC; insert bubble into EX
- ISSUE_ACCEPT  out  1  ISSUE_EN && !STALL
- PENDING1, PENDING2  out  1 each  source has an unresolved long write
- BUSY  out  1  any counter non-zero
- SB_ERROR  out  1  sticky underflow flag

## Operation
- State: NUM_REGS-1 counters cnt[1..31], CNT_W bits; cnt[0] hardwired 0.
- Increment: the counter for rd increments when ISSUE_ACCEPT && ISSUE_WRITE_EN && ISSUE_LONG && ISSUE_RD!=0.
- Decrement (WB): the counter for WB_REGISTER decrements when WB_WRITE_EN && WB_LONG && WB_REGISTER!=0.
- Decrement (kill): the counter for KILL_RD decrements when KILL_EN && KILL_RD!=0.
- Net update per register: +inc −wb −kill, applied in one edge. Increment and decrement on the same register cancel to no change. WB and KILL on the same register give −2.
- Underflow: any decrement that would take a counter below 0 leaves it at 0 and sets SB_ERROR. SB_ERROR clears only on RESET.
- Bypass resolution: for a source s, eff(s) = cnt[s] minus 1 if WB_WRITE_EN && WB_LONG && WB_REGISTER==s, else cnt[s].
- PENDINGn = ID_USESn && ADDRn!=0 && eff(ADDRn)!=0.
- STALL = PENDING1 || PENDING2 || (ISSUE_EN && ISSUE_WRITE_EN && ISSUE_LONG && ISSUE_RD!=0 && cnt[ISSUE_RD]==max). The saturation term excludes WB relief to keep the path short.
- ISSUE_EN while STALL=1 is ignored; no state change.
- Stalling is conservative. A younger ALU write to a register with an older pending load still stalls readers until the load retires.

## Timing
- STALL, ISSUE_ACCEPT, PENDINGn are combinational from current counters and this cycle's WB inputs.
- Counters update at the rising CLK edge. An issue accepted in cycle n is visible as pending in cycle n+1.
- A WB in cycle n clears the dependency in cycle n itself through the bypass. The counter reaches 0 at the edge ending cycle n.
- Load-use with 5-stage timing: load issued in cycle n, WB in cycle n+3. A dependent in ID stalls in cycles n+1 and n+2 and is accepted in n+3.
- RESET (synchronous): all counters 0, SB_ERROR 0. Outputs during and after reset: STALL 0, BUSY 0, PENDINGn 0, ISSUE_ACCEPT = ISSUE_EN.
- RESET mid-operation discards all pending state. The pipeline is flushed by the same reset.
- BUSY and SB_ERROR are registered-state derived, one cycle behind events.

## Structure
- Package rv32_pipe_pkg: REG_ADDR_W=5, NUM_REGS=32, SB_CNT_W=2, and the reg_addr_t typedef shared with the forwarding and register-file blocks.
- Sub-module sb_counter: one saturating up/down counter with inc, dec_wb, dec_kill, count, and underflow outputs. It is instantiated 31 times via generate.
- Top level: decode of ISSUE_RD, WB_REGISTER, and KILL_RD into one-hot vectors; source muxes; stall logic.

## Test plan
- Load x5, dependent add reading x5 in the next cycle: STALL=1 for exactly 2 cycles, ISSUE_ACCEPT in the WB cycle, cnt[5] back to 0, BUSY 0 afterwards.
- Writes to x0 with ISSUE_LONG=1 and reads of x0: counters unchanged, STALL never asserted.
- Three loads to x7 outstanding (cnt=3), a fourth long issue to x7: STALL=1. After one WB to x7, the fourth issues and cnt returns to 3.
- Same-cycle accepted issue and WB to x9 with cnt[9]=1: cnt[9] stays 1, and a reader of x9 stalls in the next cycle.
- KILL_EN on x12 with cnt[12]=0: cnt stays 0, SB_ERROR=1 from the next cycle, held until RESET.
- RESET asserted with cnt[3]=2 and cnt[4]=1: after one edge all counters are 0, STALL=0, BUSY=0, SB_ERROR=0.
